// File: rtl/udc_pkg.sv
// Shared definitions for the up/down modulo-N counter: direction encoding
// and the next-count rule used by the datapath.
package udc_pkg;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Next count for a counter ranging 0..modulus-1. Priority is load, then
  // step, then hold. Out-of-range load values clamp to the top count.
  // With sat set, the count holds at the terminal value instead of wrapping.
  function automatic int udc_next_count(input int   q,
                                        input logic m,
                                        input logic en,
                                        input logic ld,
                                        input int   d,
                                        input int   modulus,
                                        input logic sat);
    int r;
    r = q;
    if (ld) begin
      r = (d >= modulus) ? modulus - 1 : d;
    end else if (en) begin
      if (m == DIR_UP) begin
        if (q >= modulus - 1) r = sat ? modulus - 1 : 0;
        else                  r = q + 1;
      end else begin
        if (q == 0) r = sat ? 0 : modulus - 1;
        else        r = q - 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/udc_next.sv
// Combinational next-count logic for sync_updown_modn_counter.
// Macro UDC_SATURATE_EN: when defined, the count holds at the terminal
// value (MODULUS-1 going up, 0 going down) instead of wrapping.
module udc_next
  import udc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] q,
  input  logic             m,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nxt
);

`ifdef UDC_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  // Next count from the shared rule, narrowed back to the register width
  always_comb begin
    nxt = WIDTH'(udc_next_count(int'(q), m, en, ld, int'(d), MODULUS, SAT));
  end

endmodule

// File: rtl/sync_updown_modn_counter.sv
// Synchronous up/down modulo-MODULUS counter with parallel load, terminal
// count and cascade carry/borrow. clr is synchronous, active-high.
// Macro UDC_SATURATE_EN: when defined, the count saturates at its terminal
// value rather than wrapping (handled in udc_next).
module sync_updown_modn_counter
  import udc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             m,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             cout
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("sync_updown_modn_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] nxt;

  udc_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q  (q),
    .m  (m),
    .en (en),
    .ld (ld),
    .d  (d),
    .nxt(nxt)
  );

  // Count register; clr wins over load and step
  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else     q <= nxt;
  end

  // Complement output and terminal/cascade flags, combinational from q, m, en
  always_comb begin
    qb   = ~q;
    tc   = (m == DIR_UP) ? (q == TOP) : (q == '0);
    cout = tc & en;
  end

endmodule

// File: doc/sync_updown_modn_counter.md
SYNC_UPDOWN_MODN_COUNTER -- requirements
Module: sync_updown_modn_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter register width in bits.
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  count enable; 1 = step this cycle.
REQ-006 m  input  1  direction; 0 = up, 1 = down.
REQ-007 ld  input  1  parallel load strobe.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 q  output  WIDTH  registered count.
REQ-010 qb  output  WIDTH  bitwise complement of q.
REQ-011 tc  output  1  terminal count: q at MODULUS-1 with m=0, or q at 0 with m=1.
REQ-012 cout  output  1  cascade carry/borrow: tc AND en.

Function
REQ-013 The count update priority per rising clk edge SHALL be clr, then ld, then en, then hold.
REQ-014 With ld=1 (clr=0), q SHALL take d on the next edge; d >= MODULUS SHALL load MODULUS-1.
REQ-015 With en=1, m=0, ld=0, q SHALL increment by 1; from MODULUS-1 it SHALL wrap to 0.
REQ-016 With en=1, m=1, ld=0, q SHALL decrement by 1; from 0 it SHALL wrap to MODULUS-1.
REQ-017 With en=0, ld=0, clr=0, q SHALL hold.
REQ-018 Step latency SHALL be exactly one clk cycle from the sampled en/m/ld to updated q.
REQ-019 A change of m SHALL take effect on the same edge it is sampled; no idle cycle is inserted.
REQ-020 tc and cout SHALL be combinational from q, m, en, with no register delay.
REQ-021 qb SHALL equal ~q at all times, including during reset.
REQ-022 Arithmetic SHALL be performed modulo MODULUS inside WIDTH bits; q SHALL never exceed MODULUS-1.
REQ-023 Simultaneous ld and en SHALL perform the load only; the step is discarded.
REQ-024 Elaboration SHALL fail when MODULUS < 2 or MODULUS > 2**WIDTH.
REQ-025 Cascading: a downstream stage's en driven by an upstream cout SHALL produce a correct multi-digit count when all stages share the same m.

Reset
REQ-026 clr=1 at a rising edge SHALL set q=0 and qb=all ones, overriding ld and en.
REQ-027 After reset, tc SHALL equal m and cout SHALL equal m AND en.
REQ-028 clr asserted mid-count SHALL zero q on that edge; counting resumes on the first edge with clr=0.

Configuration
REQ-029 Macro UDC_SATURATE_EN SHALL select terminal behaviour.
REQ-030 UDC_SATURATE_EN defined: up at MODULUS-1 and down at 0 SHALL hold q; tc and cout still assert.
REQ-031 UDC_SATURATE_EN undefined: wrap per REQ-015/REQ-016.

Structure
REQ-032 Package udc_pkg SHALL hold the direction constants DIR_UP=0 and DIR_DN=1 and a next-count function shared with the bench model.
REQ-033 One sub-module, udc_next, SHALL compute the next count (combinational: q, m, en, ld, d -> next).
REQ-034 The top level SHALL contain only the state register, the qb/tc/cout logic and the udc_next instance.

Verification (WIDTH=4, MODULUS=10)
REQ-035 clr=1 for one edge, then en=1, m=0 for 12 edges -> q 1..9,0,1,2; tc=1 only at q=9.
REQ-036 Reset, then en=1, m=1 for 3 edges -> q 9,8,7; tc=1 at q=0 right after reset; wrap 0->9.
REQ-037 ld=1, d=4'd13 -> q=9 on the next edge; ld=1, en=1, d=5 together -> q=5 with no step.
REQ-038 Count up to q=6, flip m to 1 -> q 5,4 on the next two edges with no stall.
REQ-039 Two stages cascaded via cout, 25 up edges -> {hi,lo}=2,5; then clr mid-run -> both 0 on the next edge.
REQ-040 With UDC_SATURATE_EN, 15 up edges from 0 -> q stays 9 and tc=1; undefined -> wrap per REQ-035.
